// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between an ALU (A) and a load (B) writeback requester.
// After reset it optionally sweeps every register to CLEAR_VALUE, one address per cycle.
module regfile_write_arbiter #(
    parameter int             W           = 8,
    parameter int             D           = 4,
    parameter bit             CLEAR_EN    = 1'b1,
    parameter logic [W-1:0]   CLEAR_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_valid,
    input  logic [D-1:0] a_addr,
    input  logic [W-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [D-1:0] b_addr,
    input  logic [W-1:0] b_data,
    output logic         b_ready,
    output logic         busy,
    output logic         rf_write_en,
    output logic [D-1:0] rf_waddr,
    output logic [W-1:0] rf_data_in
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [D-1:0] LAST_ADDR = '1;

    state_t       state;
    state_t       state_next;
    logic [D-1:0] clr_cnt;
    logic         rr_ptr;
    logic         rr_next;
    logic         a_grant;
    logic         b_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_EN ? CLEAR : RUN;
        end else begin
            state <= state_next;
        end
    end

    // rr_ptr: 0 favours A, 1 favours B; on contention it flips to the loser.
    always_comb begin
        state_next = state;
        a_grant    = 1'b0;
        b_grant    = 1'b0;
        rr_next    = rr_ptr;
        if (state == CLEAR) begin
            if (clr_cnt == LAST_ADDR) begin
                state_next = RUN;
            end
        end else if (a_valid && b_valid) begin
            a_grant = ~rr_ptr;
            b_grant = rr_ptr;
            rr_next = ~rr_ptr;
        end else begin
            a_grant = a_valid;
            b_grant = b_valid;
        end
    end

    assign a_ready = a_grant;
    assign b_ready = b_grant;
    assign busy    = (state == CLEAR);

    // Registered write port; address/data hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt     <= '0;
            rr_ptr      <= 1'b0;
            rf_write_en <= 1'b0;
            rf_waddr    <= '0;
            rf_data_in  <= '0;
        end else if (state == CLEAR) begin
            rf_write_en <= 1'b1;
            rf_waddr    <= clr_cnt;
            rf_data_in  <= CLEAR_VALUE;
            clr_cnt     <= clr_cnt + 1'b1;
        end else begin
            rr_ptr      <= rr_next;
            rf_write_en <= a_grant | b_grant;
            if (a_grant) begin
                rf_waddr   <= a_addr;
                rf_data_in <= a_data;
            end else if (b_grant) begin
                rf_waddr   <= b_addr;
                rf_data_in <= b_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a grant/round-robin model predicts every
// ready and every register-file write; a small register-file model checks final contents.
module tb_regfile_write_arbiter;

    typedef struct {
        int         due;
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, b_valid;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, busy;
    logic       rf_write_en;
    logic [3:0] rf_waddr;
    logic [7:0] rf_data_in;

    logic       reset0;
    logic       a0_valid, b0_valid;
    logic [3:0] a0_addr, b0_addr;
    logic [7:0] a0_data, b0_data;
    logic       a0_ready, b0_ready, busy0;
    logic       rf_write_en0;
    logic [3:0] rf_waddr0;
    logic [7:0] rf_data_in0;

    logic [7:0] rf [16];
    wr_t        q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         clr_left = 0;
    logic       rr_m = 1'b0;
    logic       chk_on = 1'b0;
    logic       ga, gb;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.W(8), .D(4), .CLEAR_EN(1'b1), .CLEAR_VALUE(8'hA5)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .busy(busy), .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_data_in(rf_data_in)
    );

    regfile_write_arbiter #(.W(8), .D(4), .CLEAR_EN(1'b0), .CLEAR_VALUE(8'h00)) dut0 (
        .clk(clk), .reset(reset0),
        .a_valid(a0_valid), .a_addr(a0_addr), .a_data(a0_data), .a_ready(a0_ready),
        .b_valid(b0_valid), .b_addr(b0_addr), .b_data(b0_data), .b_ready(b0_ready),
        .busy(busy0), .rf_write_en(rf_write_en0), .rf_waddr(rf_waddr0), .rf_data_in(rf_data_in0)
    );

    always @(posedge clk) begin
        if (rf_write_en) rf[rf_waddr] <= rf_data_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: check outputs at negedge against the model, push new expected writes.
    task automatic step(output logic ea_o, output logic eb_o);
        wr_t  e;
        logic be, ea, eb;
        @(negedge clk);
        be = (clr_left > 0);
        ea = !be && a_valid && (!b_valid || !rr_m);
        eb = !be && b_valid && (!a_valid || rr_m);
        if (chk_on) begin
            check("busy", busy, be);
            check("a_ready", a_ready, ea);
            check("b_ready", b_ready, eb);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("we", rf_write_en, 1);
                check("waddr", rf_waddr, e.addr);
                check("wdata", rf_data_in, e.data);
            end else begin
                check("we_idle", rf_write_en, 0);
            end
        end
        if (ea) q.push_back('{cyc + 1, a_addr, a_data});
        if (eb) q.push_back('{cyc + 1, b_addr, b_data});
        if (!be && a_valid && b_valid) rr_m = ea;
        if (reset) begin
            q.delete();
            rr_m     = 1'b0;
            clr_left = 16;
            for (int i = 0; i < 16; i++) q.push_back('{cyc + 2 + i, 4'(i), 8'hA5});
        end else if (clr_left > 0) begin
            clr_left--;
        end
        ea_o = ea;
        eb_o = eb;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        logic x, y;
        for (int i = 0; i < n; i++) step(x, y);
    endtask

    task automatic check_all_cleared(input string tag);
        for (int i = 0; i < 16; i++) check(tag, rf[i], 8'hA5);
    endtask

    initial begin
        reset = 1'b1; reset0 = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        a0_valid = 1'b0; b0_valid = 1'b0;
        a0_addr = '0; b0_addr = '0; a0_data = '0; b0_data = '0;

        // Reset and full clear sweep with value A5.
        step(ga, gb);
        reset  = 1'b0;
        chk_on = 1'b1;
        idle(18);
        check_all_cleared("clear_rf");

        // Lone A request.
        a_valid = 1'b1; a_addr = 4'd3; a_data = 8'h42;
        step(ga, gb);
        check("t2_grant", ga, 1);
        a_valid = 1'b0;
        idle(2);
        check("t2_reg3", rf[3], 8'h42);

        // Both valid for four cycles: alternating grants, continuous writes.
        a_valid = 1'b1; a_addr = 4'd1; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 4'd2; b_data = 8'h22;
        for (int k = 0; k < 4; k++) begin
            step(ga, gb);
            if (ga) a_data = a_data + 8'h01;
            if (gb) b_data = b_data + 8'h01;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        idle(2);

        // Same address from both: grant order decides the final value.
        a_valid = 1'b1; a_addr = 4'd5; a_data = 8'h10;
        b_valid = 1'b1; b_addr = 4'd5; b_data = 8'h20;
        step(ga, gb);
        if (ga) a_valid = 1'b0;
        if (gb) b_valid = 1'b0;
        step(ga, gb);
        a_valid = 1'b0; b_valid = 1'b0;
        idle(2);
        check("t4_reg5", rf[5], 8'h20);

        // Reset in the middle of a clear sweep restarts it at address 0.
        reset = 1'b1;
        step(ga, gb);
        reset = 1'b0;
        idle(7);
        reset = 1'b1;
        step(ga, gb);
        reset = 1'b0;
        idle(18);
        check_all_cleared("reclear_rf");

        // Reset in the same cycle A is accepted: that write must be dropped.
        a_valid = 1'b1; a_addr = 4'd9; a_data = 8'h77;
        reset = 1'b1;
        step(ga, gb);
        check("t5_acc_before_reset", ga, 1);
        reset = 1'b0; a_valid = 1'b0;
        idle(18);

        // Random traffic with holds and withdrawals.
        for (int k = 0; k < 200; k++) begin
            if (!a_valid || ga) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_addr  = 4'($urandom_range(0, 15));
                a_data  = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 7) == 0) begin
                a_valid = 1'b0;
            end
            if (!b_valid || gb) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_addr  = 4'($urandom_range(0, 15));
                b_data  = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 7) == 0) begin
                b_valid = 1'b0;
            end
            step(ga, gb);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        idle(3);
        check("queue_drained", q.size(), 0);

        // Instance without a clear sweep: usable immediately after reset.
        step(ga, gb);
        check("t6_busy_in_reset", busy0, 0);
        reset0 = 1'b0;
        a0_valid = 1'b1; a0_addr = 4'd6; a0_data = 8'h5C;
        #1;
        check("t6_busy", busy0, 0);
        check("t6_a_ready", a0_ready, 1);
        check("t6_we_pre", rf_write_en0, 0);
        step(ga, gb);
        a0_valid = 1'b0;
        #1;
        check("t6_we", rf_write_en0, 1);
        check("t6_waddr", rf_waddr0, 4'd6);
        check("t6_wdata", rf_data_in0, 8'h5C);
        check("t6_a_ready_idle", a0_ready, 0);
        step(ga, gb);
        check("t6_we_idle", rf_write_en0, 0);
        check("t6_waddr_hold", rf_waddr0, 4'd6);
        check("t6_busy_after", busy0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
